lfsr_decrypt_param: RTL and testbench
=====================================

LFSR_DECRYPT_PARAM -- requirements
Module: lfsr_decrypt_param

Interface
REQ-001 SHALL have parameter W, default 6: LFSR width, legal range 3..8.
REQ-002 SHALL have parameter NPAT, default 6: number of candidate tap patterns, legal range 1..16.
REQ-003 SHALL have parameter TAPS, default {6'h39,6'h36,6'h33,6'h30,6'h2D,6'h21}: NPAT*W packed bits; pattern k is bits [k*W +: W].
REQ-004 SHALL have parameter DEPTH, default 64: message length in bytes.
REQ-005 SHALL have parameter AW, default 8: memory address width.
REQ-006 SHALL have parameters SRC_BASE (default 64), DST_BASE (default 0), PRE_CHAR (default 8'h5F) and PAD_CHAR (default 8'h20).
REQ-007 SHALL have port clk, input, 1 bit: clock; all logic is rising-edge triggered.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-009 SHALL have port start, input, 1 bit: a high sample while idle begins one job.
REQ-010 SHALL have port mem_raddr, output, AW bits: read address.
REQ-011 SHALL have port mem_rdata, input, 8 bits: read data, valid exactly one cycle after the address.
REQ-012 SHALL have ports mem_we (output, 1 bit), mem_waddr (output, AW bits) and mem_wdata (output, 8 bits): write port, committed on the edge when mem_we=1.
REQ-013 SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until done.
REQ-014 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-015 SHALL have port err, output, 1 bit: the job found no usable tap pattern.
REQ-016 SHALL have port found_idx, output, 4 bits: index of the selected tap pattern.
REQ-017 SHALL have port strip_cnt, output, AW+1 bits: number of leading PRE_CHAR bytes removed.

Function
REQ-018 SHALL implement FSM states IDLE, SEED, PROBE, SELECT, DECODE, FILL, FINISH.
REQ-019 SHALL compute the LFSR step as next = {s[W-2:0], ^(s & tap)}, in W-bit arithmetic.
REQ-020 SHALL, in SEED, read src[0] at address SRC_BASE and set seed = src[0][W-1:0] ^ PRE_CHAR[W-1:0].
REQ-021 SHALL, if seed == 0, set err=1, perform no writes and go to FINISH.
REQ-022 SHALL, in PROBE, read src[1..W] at one byte per cycle, pipelined.
REQ-023 SHALL, in PROBE, keep an NPAT-bit alive mask (all ones at entry); bit k clears when candidate k's j-th step state differs from src[j][W-1:0] ^ PRE_CHAR[W-1:0].
REQ-024 SHALL, in SELECT, choose the lowest-index alive pattern and latch it into found_idx; if no bit is alive, set err=1, perform no writes and go to FINISH.
REQ-025 SHALL, in DECODE, read src[i] for i = 0..DEPTH-1 at one byte per cycle, pipelined.
REQ-026 SHALL, in DECODE, compute plain[i] = src[i] ^ {(8-W)'b0, lfsr_i}, where lfsr_0 = seed, then step the LFSR once per byte.
REQ-027 SHALL, while the leading run is active, skip each plain byte equal to PRE_CHAR and increment strip_cnt.
REQ-028 SHALL end the leading run permanently at the first plain byte not equal to PRE_CHAR.
REQ-029 SHALL, after the leading run ends, write each plain byte to DST_BASE + wptr and increment wptr (reset to 0 at job start).
REQ-030 SHALL never write a PRE_CHAR byte that appears after the leading run ends as a stripped byte; it is written normally.
REQ-031 SHALL, in FILL, write PAD_CHAR to DST_BASE + wptr for wptr up to DEPTH-1, one write per cycle.
REQ-032 SHALL skip FILL when wptr == DEPTH.
REQ-033 SHALL write only addresses in DST_BASE .. DST_BASE+DEPTH-1.
REQ-034 SHALL, in FINISH, pulse done=1 for one cycle, deassert busy in that same cycle, and return to IDLE.
REQ-035 SHALL complete each job with done asserted within 2*DEPTH + W + 8 cycles of start acceptance.
REQ-036 SHALL ignore start while busy=1.
REQ-037 SHALL accept start on the cycle after done.
REQ-038 SHALL, when start is accepted, clear err, strip_cnt, found_idx and wptr.
REQ-039 SHALL hold err, strip_cnt and found_idx stable from done until the next accepted start.
REQ-040 SHALL keep mem_we=0 in IDLE, SEED, PROBE, SELECT and FINISH.

Reset
REQ-041 SHALL, while rst=1, set the state to IDLE and drive busy=0, done=0, err=0, mem_we=0, found_idx=0, strip_cnt=0, mem_raddr=0, mem_waddr=0, mem_wdata=0.
REQ-042 SHALL, on rst asserted mid-job, perform no write on or after the reset edge, discard the job, and never assert done for it.
REQ-043 SHALL give rst priority over start when both are high in the same cycle.

Verification
REQ-044 SHALL be verified by: seed 6'h01, tap 6'h33, 10 leading '_', then "HELLO", rest '_' -> found_idx=3, strip_cnt=10, dst[0..4]="HELLO", dst[5..] equal to the trailing '_' bytes, err=0, one done pulse.
REQ-045 SHALL be verified by: random ciphertext matching no pattern -> err=1, no mem_we cycles, done within W+8 cycles.
REQ-046 SHALL be verified by: a message made entirely of PRE_CHAR -> strip_cnt=DEPTH, dst[0..DEPTH-1]=8'h20.
REQ-047 SHALL be verified by: seed 0 (src[0]=8'h5F) -> err=1, no writes.
REQ-048 SHALL be verified by: start re-pulsed during DECODE -> ignored, single done; rst asserted mid-DECODE -> no later writes, busy=0 next cycle, no done.
REQ-049 SHALL be verified by: W=7, NPAT=2, DEPTH=32, tap 7'h41 -> correct decode and found_idx, with writes confined to DST_BASE..DST_BASE+31.

Source files
------------

// File: rtl/lfsr_decrypt_param.sv
// -----------------------------------------------------------------------------
// lfsr_decrypt_param
//
// Recovers an LFSR-encrypted message held in memory and writes the plaintext
// back out. The known leading PRE_CHAR byte yields the seed. The next W
// ciphertext bytes are used to probe NPAT candidate tap patterns, and the
// lowest-index surviving pattern decrypts the whole message. The leading run
// of PRE_CHAR bytes is stripped, the rest is written compacted from DST_BASE,
// and the tail of the destination is padded with PAD_CHAR.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   begins a job when sampled high while idle
//   mem_raddr  out  read address (registered)
//   mem_rdata  in   read data, valid the cycle after mem_raddr
//   mem_we     out  write enable, committed on the next rising edge
//   mem_waddr  out  write address (registered)
//   mem_wdata  out  write data (registered)
//   busy       out  job in progress
//   done       out  one-cycle completion pulse
//   err        out  job found no usable seed / tap pattern
//   found_idx  out  index of the selected tap pattern
//   strip_cnt  out  number of leading PRE_CHAR bytes removed
// -----------------------------------------------------------------------------
module lfsr_decrypt_param #(
    parameter int              W        = 6,
    parameter int              NPAT     = 6,
    parameter logic [NPAT*W-1:0] TAPS   = {6'h39, 6'h36, 6'h33, 6'h30, 6'h2D, 6'h21},
    parameter int              DEPTH    = 64,
    parameter int              AW       = 8,
    parameter int              SRC_BASE = 64,
    parameter int              DST_BASE = 0,
    parameter logic [7:0]      PRE_CHAR = 8'h5F,
    parameter logic [7:0]      PAD_CHAR = 8'h20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [AW-1:0] mem_raddr,
    input  logic [7:0]    mem_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [7:0]    mem_wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [3:0]    found_idx,
    output logic [AW:0]   strip_cnt
);

    localparam logic [AW-1:0] SRC_A   = AW'(SRC_BASE);
    localparam logic [AW-1:0] DST_A   = AW'(DST_BASE);
    localparam logic [AW:0]   PROBE_N = (AW+1)'(W);
    localparam logic [AW:0]   LAST_I  = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEED   = 3'd1,
        PROBE  = 3'd2,
        SELECT = 3'd3,
        DECODE = 3'd4,
        FILL   = 3'd5,
        FINISH = 3'd6
    } state_t;

    // One Fibonacci-style LFSR step: shift left, feedback is parity of tapped bits.
    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s, input logic [W-1:0] tap);
        return {s[W-2:0], ^(s & tap)};
    endfunction

    state_t          state_q;
    logic            phase_q;
    logic [AW:0]     cnt_q;
    logic [W-1:0]    seed_q;
    logic [W-1:0]    cand_q [NPAT];
    logic [NPAT-1:0] alive_q;
    logic [W-1:0]    tap_q;
    logic [W-1:0]    lfsr_q;
    logic            run_q;
    logic [AW:0]     wptr_q;
    logic [AW-1:0]   raddr_q;
    logic            we_q;
    logic [AW-1:0]   waddr_q;
    logic [7:0]      wdata_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic [3:0]      idx_q;
    logic [AW:0]     strip_q;

    logic [W-1:0]    ref_s;
    logic [W-1:0]    cand_d [NPAT];
    logic [NPAT-1:0] alive_d;
    logic            sel_found_s;
    logic [3:0]      sel_idx_s;
    logic [W-1:0]    sel_tap_s;
    logic [7:0]      ks_s;
    logic [7:0]      plain_s;

    // Known-plaintext keystream reference: low W bits of the byte XOR PRE_CHAR.
    assign ref_s   = mem_rdata[W-1:0] ^ PRE_CHAR[W-1:0];
    assign ks_s    = 8'(lfsr_q);
    assign plain_s = mem_rdata ^ ks_s;

    // Advance every candidate LFSR and drop those that disagree with the reference.
    always_comb begin
        alive_d = '0;
        for (int k = 0; k < NPAT; k++) begin
            cand_d[k]  = lfsr_step(cand_q[k], TAPS[k*W +: W]);
            alive_d[k] = alive_q[k] & (cand_d[k] == ref_s);
        end
    end

    // Priority pick of the lowest-index surviving pattern (scan high to low, last hit wins).
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = 4'd0;
        sel_tap_s   = '0;
        for (int k = NPAT - 1; k >= 0; k--) begin
            sel_found_s = sel_found_s | alive_q[k];
            sel_idx_s   = alive_q[k] ? 4'(k) : sel_idx_s;
            sel_tap_s   = alive_q[k] ? TAPS[k*W +: W] : sel_tap_s;
        end
    end

    // Control FSM with all datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= 1'b0;
            cnt_q   <= '0;
            seed_q  <= '0;
            for (int k = 0; k < NPAT; k++) begin
                cand_q[k] <= '0;
            end
            alive_q <= '0;
            tap_q   <= '0;
            lfsr_q  <= '0;
            run_q   <= 1'b0;
            wptr_q  <= '0;
            raddr_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= 4'd0;
            strip_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    we_q   <= 1'b0;
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q  <= 1'b1;
                        err_q   <= 1'b0;
                        strip_q <= '0;
                        idx_q   <= 4'd0;
                        wptr_q  <= '0;
                        raddr_q <= SRC_A;
                        phase_q <= 1'b0;
                        state_q <= SEED;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SEED: begin
                    // Phase 0 waits for src[0]; its address is already on the bus.
                    if (!phase_q) begin
                        phase_q <= 1'b1;
                        raddr_q <= SRC_A + 1'b1;
                    end else begin
                        seed_q <= ref_s;
                        if (ref_s == '0) begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end else begin
                            for (int k = 0; k < NPAT; k++) begin
                                cand_q[k] <= ref_s;
                            end
                            alive_q <= '1;
                            cnt_q   <= (AW+1)'(1);
                            raddr_q <= raddr_q + 1'b1;
                            state_q <= PROBE;
                        end
                    end
                end
                PROBE: begin
                    for (int k = 0; k < NPAT; k++) begin
                        cand_q[k] <= cand_d[k];
                    end
                    alive_q <= alive_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == PROBE_N) begin
                        // Pre-issue src[0] so DECODE starts with data in hand.
                        raddr_q <= SRC_A;
                        state_q <= SELECT;
                    end else begin
                        raddr_q <= raddr_q + 1'b1;
                    end
                end
                SELECT: begin
                    if (!sel_found_s) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FINISH;
                    end else begin
                        idx_q   <= sel_idx_s;
                        tap_q   <= sel_tap_s;
                        lfsr_q  <= seed_q;
                        run_q   <= 1'b1;
                        cnt_q   <= '0;
                        raddr_q <= SRC_A + 1'b1;
                        state_q <= DECODE;
                    end
                end
                DECODE: begin
                    lfsr_q  <= lfsr_step(lfsr_q, tap_q);
                    raddr_q <= raddr_q + 1'b1;
                    cnt_q   <= cnt_q + 1'b1;
                    if (run_q && (plain_s == PRE_CHAR)) begin
                        strip_q <= strip_q + 1'b1;
                        we_q    <= 1'b0;
                    end else begin
                        // First non-prefix byte closes the leading run for good.
                        run_q   <= 1'b0;
                        we_q    <= 1'b1;
                        waddr_q <= DST_A + wptr_q[AW-1:0];
                        wdata_q <= plain_s;
                        wptr_q  <= wptr_q + 1'b1;
                    end
                    if (cnt_q == LAST_I) begin
                        state_q <= FILL;
                    end else begin
                        state_q <= DECODE;
                    end
                end
                FILL: begin
                    // The wptr == DEPTH cycle lets the final write retire before FINISH.
                    if (wptr_q == DEPTH_C) begin
                        we_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FINISH;
                    end else begin
                        we_q    <= 1'b1;
                        waddr_q <= DST_A + wptr_q[AW-1:0];
                        wdata_q <= PAD_CHAR;
                        wptr_q  <= wptr_q + 1'b1;
                    end
                end
                FINISH: begin
                    we_q    <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    we_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Reset gates the enable so a pending write never commits on the reset edge.
    assign mem_we    = we_q & ~rst;
    assign mem_raddr = raddr_q;
    assign mem_waddr = waddr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign found_idx = idx_q;
    assign strip_cnt = strip_q;

endmodule

// File: tb/tb_lfsr_decrypt_param.sv
// -----------------------------------------------------------------------------
// tb_lfsr_decrypt_param
//
// Bench for lfsr_decrypt_param. Instance 0 uses default parameters, instance 1
// uses W=7, NPAT=2, DEPTH=32. Each has a behavioural memory; a reference model
// pushes expected writes into a queue that a monitor pops on every DUT write.
// -----------------------------------------------------------------------------
module tb_lfsr_decrypt_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start0, start1;
    logic [7:0] raddr0, rdata0, waddr0, wdata0, raddr1, rdata1, waddr1, wdata1;
    logic       we0, busy0, done0, err0, we1, busy1, done1, err1;
    logic [3:0] idx0, idx1;
    logic [8:0] strip0, strip1;

    lfsr_decrypt_param u_dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .mem_raddr(raddr0), .mem_rdata(rdata0),
        .mem_we(we0), .mem_waddr(waddr0), .mem_wdata(wdata0),
        .busy(busy0), .done(done0), .err(err0),
        .found_idx(idx0), .strip_cnt(strip0)
    );

    lfsr_decrypt_param #(
        .W(7), .NPAT(2), .TAPS({7'h41, 7'h44}), .DEPTH(32)
    ) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .mem_raddr(raddr1), .mem_rdata(rdata1),
        .mem_we(we1), .mem_waddr(waddr1), .mem_wdata(wdata1),
        .busy(busy1), .done(done1), .err(err1),
        .found_idx(idx1), .strip_cnt(strip1)
    );

    logic [7:0] src0 [64];
    logic [7:0] src1 [32];
    logic [7:0] dst0 [256];
    logic [7:0] dst1 [256];
    logic [7:0] pb   [64];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt0 = 0, done_cnt1 = 0, done_cyc0 = 0, done_cyc1 = 0;
    int we_cnt0 = 0, we_cnt1 = 0, we_after_rst = 0;
    bit post_rst = 1'b0;
    bit sb_en0 = 1'b1, sb_en1 = 1'b1;
    int q0 [$];
    int q1 [$];
    int exp_err, exp_idx, exp_strip;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memories: src regions read-only images, dst regions take DUT writes.
    always @(posedge clk) begin
        if (raddr0 >= 8'd64 && raddr0 < 8'd128) rdata0 <= src0[raddr0 - 8'd64];
        else rdata0 <= dst0[raddr0];
        if (raddr1 >= 8'd64 && raddr1 < 8'd96) rdata1 <= src1[raddr1 - 8'd64];
        else rdata1 <= dst1[raddr1];
        if (we0) dst0[waddr0] <= wdata0;
        if (we1) dst1[waddr1] <= wdata1;
    end

    always @(posedge clk) cyc++;

    task automatic sb_pop(input int inst, input logic [7:0] a, input logic [7:0] d);
        int e;
        if (inst == 0) begin
            check("sb0_pending", q0.size() > 0, 1);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("sb0_waddr", a, e >> 8);
                check("sb0_wdata", d, e & 255);
            end
            check("wr_range0", a < 8'd64, 1);
        end else begin
            check("sb1_pending", q1.size() > 0, 1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("sb1_waddr", a, e >> 8);
                check("sb1_wdata", d, e & 255);
            end
            check("wr_range1", a < 8'd32, 1);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (done0) begin done_cnt0++; done_cyc0 = cyc; end
        if (done1) begin done_cnt1++; done_cyc1 = cyc; end
        if (we0) begin
            we_cnt0++;
            if (post_rst) we_after_rst++;
            if (sb_en0) sb_pop(0, waddr0, wdata0);
        end
        if (we1) begin
            we_cnt1++;
            if (post_rst) we_after_rst++;
            if (sb_en1) sb_pop(1, waddr1, wdata1);
        end
    end

    function automatic int mstep(input int s, input int tap, input int w);
        int p;
        p = $countones(s & tap) & 1;
        return ((s << 1) | p) & ((1 << w) - 1);
    endfunction

    function automatic int sbyte(input int inst, input int i);
        return (inst == 0) ? int'(src0[i]) : int'(src1[i]);
    endfunction

    // Reference model: fills exp_* and queues the expected write stream.
    task automatic model(input int inst);
        int w, depth, npat, mask, seed, s, lf, p, wptr, run;
        int taps [6];
        bit alive [6];
        w     = (inst == 0) ? 6 : 7;
        depth = (inst == 0) ? 64 : 32;
        npat  = (inst == 0) ? 6 : 2;
        if (inst == 0) taps = '{32'h21, 32'h2D, 32'h30, 32'h33, 32'h36, 32'h39};
        else           taps = '{32'h44, 32'h41, 0, 0, 0, 0};
        mask = (1 << w) - 1;
        exp_err = 0; exp_idx = 0; exp_strip = 0;
        seed = (sbyte(inst, 0) ^ 32'h5F) & mask;
        if (seed == 0) begin exp_err = 1; return; end
        for (int k = 0; k < npat; k++) begin
            alive[k] = 1'b1;
            s = seed;
            for (int j = 1; j <= w; j++) begin
                s = mstep(s, taps[k], w);
                if (s != ((sbyte(inst, j) ^ 32'h5F) & mask)) alive[k] = 1'b0;
            end
        end
        exp_idx = -1;
        for (int k = npat - 1; k >= 0; k--) if (alive[k]) exp_idx = k;
        if (exp_idx < 0) begin exp_err = 1; exp_idx = 0; return; end
        lf = seed; run = 1; wptr = 0;
        for (int i = 0; i < depth; i++) begin
            p = sbyte(inst, i) ^ lf;
            lf = mstep(lf, taps[exp_idx], w);
            if (run != 0 && p == 32'h5F) exp_strip++;
            else begin
                run = 0;
                if (inst == 0) q0.push_back(wptr * 256 + p); else q1.push_back(wptr * 256 + p);
                wptr++;
            end
        end
        for (; wptr < depth; wptr++) begin
            if (inst == 0) q0.push_back(wptr * 256 + 32'h20); else q1.push_back(wptr * 256 + 32'h20);
        end
    endtask

    task automatic encrypt(input int inst, input int seed, input int tap);
        int w, depth, lf;
        w = (inst == 0) ? 6 : 7;
        depth = (inst == 0) ? 64 : 32;
        lf = seed;
        for (int i = 0; i < depth; i++) begin
            if (inst == 0) src0[i] = pb[i] ^ 8'(lf); else src1[i] = pb[i] ^ 8'(lf);
            lf = mstep(lf, tap, w);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int inst, output int acc);
        if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
        tick(1);
        acc = cyc;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int inst, input int d0, input int acc, output int lat);
        int n = 0;
        while (((inst == 0) ? done_cnt0 : done_cnt1) == d0 && n < 400) begin
            tick(1);
            n++;
        end
        lat = ((inst == 0) ? done_cyc0 : done_cyc1) - acc;
        tick(4);
        check("single_done", ((inst == 0) ? done_cnt0 : done_cnt1) - d0, 1);
    endtask

    task automatic run_job(input int inst, output int lat);
        int acc, d0;
        d0 = (inst == 0) ? done_cnt0 : done_cnt1;
        start_job(inst, acc);
        wait_done(inst, d0, acc, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, acc, d0, web, bad, tries;
        logic [39:0] hello_v;
        hello_v = "HELLO";
        for (int i = 0; i < 64; i++) src0[i] = 8'h00;
        for (int i = 0; i < 32; i++) src1[i] = 8'h00;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        tick(3);

        // Reset state
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_err", err0, 0);
        check("rst_we", we0, 0);
        check("rst_idx", idx0, 0);
        check("rst_strip", strip0, 0);
        check("rst_raddr", raddr0, 0);
        check("rst_waddr", waddr0, 0);
        check("rst_wdata", wdata0, 0);

        // rst wins over start in the same cycle
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0; rst = 1'b0;
        tick(1);
        check("rst_prio_busy", busy0, 0);

        // HELLO message, seed 1, tap 6'h33
        for (int i = 0; i < 64; i++) pb[i] = 8'h5F;
        for (int i = 0; i < 5; i++) pb[10 + i] = hello_v[39 - 8*i -: 8];
        encrypt(0, 1, 32'h33);
        q0.delete();
        model(0);
        run_job(0, lat);
        check("hello_idx", idx0, 3);
        check("hello_strip", strip0, 10);
        check("hello_strip_model", strip0, exp_strip);
        check("hello_err", err0, 0);
        check("hello_q_empty", q0.size(), 0);
        check("hello_latency", lat <= 142, 1);
        for (int i = 0; i < 5; i++) check("hello_dst", dst0[i], hello_v[39 - 8*i -: 8]);

        // Random ciphertext matching no pattern
        tries = 0;
        do begin
            q0.delete();
            for (int i = 0; i < 64; i++) src0[i] = 8'($urandom_range(0, 255));
            src0[0] = 8'h5E;
            model(0);
            tries++;
        end while (exp_err == 0 && tries < 20);
        web = we_cnt0;
        run_job(0, lat);
        check("nomatch_err", err0, 1);
        check("nomatch_writes", we_cnt0 - web, 0);
        check("nomatch_latency", lat <= 14, 1);
        check("nomatch_busy", busy0, 0);

        // All-PRE_CHAR message
        for (int i = 0; i < 64; i++) pb[i] = 8'h5F;
        encrypt(0, 32'h15, 32'h30);
        q0.delete();
        model(0);
        run_job(0, lat);
        check("allpre_strip", strip0, 64);
        check("allpre_err", err0, 0);
        check("allpre_idx", idx0, exp_idx);
        check("allpre_q_empty", q0.size(), 0);
        bad = 0;
        for (int i = 0; i < 64; i++) if (dst0[i] !== 8'h20) bad++;
        check("allpre_dst_pad", bad, 0);

        // Seed zero
        src0[0] = 8'h5F;
        q0.delete();
        web = we_cnt0;
        run_job(0, lat);
        check("seed0_err", err0, 1);
        check("seed0_writes", we_cnt0 - web, 0);
        check("seed0_strip_held", strip0, 0);

        // start re-pulsed during DECODE is ignored
        for (int i = 0; i < 64; i++) pb[i] = (i < 8) ? 8'h5F : 8'($urandom_range(32, 126));
        encrypt(0, 32'h2A, 32'h2D);
        q0.delete();
        model(0);
        d0 = done_cnt0;
        start_job(0, acc);
        tick(20);
        check("repulse_busy", busy0, 1);
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        wait_done(0, d0, acc, lat);
        check("repulse_idx", idx0, exp_idx);
        check("repulse_strip", strip0, exp_strip);
        check("repulse_q_empty", q0.size(), 0);
        check("repulse_idle", busy0, 0);

        // rst mid-DECODE: job discarded
        sb_en0 = 1'b0;
        d0 = done_cnt0;
        start_job(0, acc);
        tick(30);
        check("midrst_busy_before", busy0, 1);
        rst = 1'b1; post_rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_busy_after", busy0, 0);
        tick(100);
        check("midrst_no_done", done_cnt0 - d0, 0);
        check("midrst_no_writes", we_after_rst, 0);
        post_rst = 1'b0;
        q0.delete();
        sb_en0 = 1'b1;

        // W=7 instance, tap 7'h41
        for (int i = 0; i < 32; i++) pb[i] = (i < 8) ? 8'h5F : 8'($urandom_range(97, 122));
        for (int i = 0; i < 5; i++) pb[8 + i] = hello_v[39 - 8*i -: 8];
        encrypt(1, 32'h05, 32'h41);
        q1.delete();
        model(1);
        run_job(1, lat);
        check("w7_idx", idx1, 1);
        check("w7_idx_model", idx1, exp_idx);
        check("w7_strip", strip1, 8);
        check("w7_err", err1, 0);
        check("w7_q_empty", q1.size(), 0);
        check("w7_latency", lat <= 79, 1);
        for (int i = 0; i < 5; i++) check("w7_dst", dst1[i], hello_v[39 - 8*i -: 8]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
